video_line_sequencer: RTL and testbench
=======================================

# video_line_sequencer

Scanline scheduler for the whizgraphics renderer. Generates the Game Boy LCD dot/line timing: OAM scan, pixel transfer, HBlank and VBlank modes. Issues one `drawline` pulse per visible line, then holds pixel-transfer mode until the renderer reports `renderComplete`. Sits between the LCD control registers and whizgraphics, and is the only source of `drawline` and LY in the video subsystem.

## Interface
Parameters:
- `DOTS_PER_LINE`, 456, dots per scanline (one dot per `clk`)
- `LINES_PER_FRAME`, 154, total lines including VBlank
- `VISIBLE_LINES`, 144, lines that are rendered
- `OAM_DOTS`, 80, length of OAM scan
- `MIN_DRAW_DOTS`, 172, minimum pixel-transfer length

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `lcd_en`  in  1  LCD enable (LCDC bit 7)
- `renderComplete`  in  1  renderer line-done level/pulse
- `lyc`  in  8  LY compare value
- `lyc_irq_en`  in  1  STAT LYC interrupt enable
- `drawline`  out  1  one-cycle start-of-line pulse to renderer
- `ly`  out  8  current line, 0..153
- `mode`  out  2  `video_mode_t`: 0 HBlank, 1 VBlank, 2 OAM, 3 Draw
- `vblank_irq`  out  1  one-cycle pulse at VBlank entry
- `stat_irq`  out  1  one-cycle pulse on LY==LYC rising edge
- `ly_eq`  out  1  registered LY==LYC flag
- `overrun`  out  1  sticky: renderer missed a line deadline

## Operation
- States: OFF, OAM, DRAW, HBLANK, VBLANK. Internal `dot` counter runs 0..DOTS_PER_LINE-1.
- OFF:
  - Entered from reset or whenever `lcd_en`=0, regardless of current state.
  - Outputs: `dot`=0, `ly`=0, `mode`=0.
  - First cycle with `lcd_en`=1 enters OAM at line 0, dot 0.
- OAM: dots 0..OAM_DOTS-1. At dot OAM_DOTS, enter DRAW and assert `drawline` for that single cycle.
- DRAW:
  - `done_seen` latch clears on entry.
  - It sets on any cycle after the `drawline` cycle in which `renderComplete`=1.
  - Exit to HBLANK on the first cycle where `dot` ≥ OAM_DOTS+MIN_DRAW_DOTS and `done_seen` (or `renderComplete`) is set.
- Overrun: if DRAW is still active at `dot`=DOTS_PER_LINE-1, set `overrun` (sticky until `reset`) and advance to the next line normally.
- HBLANK: runs until `dot`=DOTS_PER_LINE-1. Then `ly`+1 and `dot` wraps to 0. Next state is OAM if the new `ly` < VISIBLE_LINES, else VBLANK.
- VBLANK:
  - Covers lines VISIBLE_LINES..LINES_PER_FRAME-1.
  - `vblank_irq` pulses on the cycle `ly` becomes VISIBLE_LINES.
  - After the last dot of line LINES_PER_FRAME-1, `ly` wraps to 0 and the state goes to OAM.
- No `drawline` is issued in VBLANK or OFF.
- Arithmetic:
  - `dot` is 9 bits, `ly` is 8 bits.
  - Both wrap by compare-and-clear, never by natural overflow.

## Timing
- Reset values: `drawline`=0, `ly`=0, `mode`=0, `vblank_irq`=0, `stat_irq`=0, `ly_eq`=0, `overrun`=0.
- All outputs are registered.
- `mode` and `ly` change on the same edge as the state/dot transition.
- `drawline` coincides with the first DRAW cycle (`mode`=3).
- `renderComplete` to HBLANK latency: one cycle once the minimum draw length has elapsed.
- `renderComplete` asserted outside DRAW is ignored.
- `lcd_en` falling mid-line: OFF on the next edge. An in-flight render is abandoned and no `overrun` is flagged.
- `reset` mid-line: OFF on the next edge; all outputs return to their reset values, including `overrun`.
- Line wrap and VBlank entry on the same edge: `vblank_irq` and `ly`=144 appear together.

## Configuration
- `VIDEO_SEQ_LYC_EN` defined:
  - `ly_eq` is registered `ly==lyc`.
  - `stat_irq` pulses one cycle on the `ly_eq` 0→1 transition when `lyc_irq_en`=1.
- `VIDEO_SEQ_LYC_EN` undefined:
  - `lyc` and `lyc_irq_en` are ignored.
  - `ly_eq` and `stat_irq` are tied 0.
  - Ports remain present.

## Structure
- `video_types` package: `video_mode_t` enum (MODE_HBLANK=0, MODE_VBLANK=1, MODE_OAM=2, MODE_DRAW=3), `seq_state_t` enum, and the default timing constants.
- One sub-module, `video_dot_counter`:
  - Holds the dot/line counters.
  - Produces `line_end`, `frame_end` and `ly`.
- The top level holds the FSM and the IRQ logic.

## Test plan
- Reset held 3 cycles with `lcd_en`=1, then released → all outputs 0 during reset; `mode`=2 and `ly`=0 on the first cycle after release; `drawline` on cycle 80.
- `renderComplete` pulsed at dot 200 → `mode`=0 from dot 252, `ly`=1 after dot 455, `overrun`=0.
- `renderComplete` at dot 300 → `mode`=0 at dot 301.
- `renderComplete` never asserted on line 7 → `overrun`=1 after dot 455, line 8 starts in OAM, and `overrun` stays set.
- Full frame with prompt completion → exactly 144 `drawline` pulses and one `vblank_irq` with `ly`=144, `mode`=1; wrap to `ly`=0 after 70224 cycles.
- `lcd_en` dropped at line 3, dot 120 → `ly`=0, `mode`=0 next cycle, no `drawline`.
- Additional check, run with `VIDEO_SEQ_LYC_EN` defined: `lyc`=5, `lyc_irq_en`=1 → `stat_irq` pulses once at `ly`=5 entry.

Source files
------------

// File: rtl/video_types.sv
// Shared types and default timing constants for the LCD line sequencer.
package video_types;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_DRAW   = 2'd3
  } video_mode_t;

  typedef enum logic [2:0] {
    StOff,
    StOam,
    StDraw,
    StHblank,
    StVblank
  } seq_state_t;

  localparam int unsigned DefDotsPerLine   = 456;
  localparam int unsigned DefLinesPerFrame = 154;
  localparam int unsigned DefVisibleLines  = 144;
  localparam int unsigned DefOamDots       = 80;
  localparam int unsigned DefMinDrawDots   = 172;

  function automatic video_mode_t mode_of(input seq_state_t st);
    video_mode_t m;
    case (st)
      StOam:    m = MODE_OAM;
      StDraw:   m = MODE_DRAW;
      StVblank: m = MODE_VBLANK;
      default:  m = MODE_HBLANK;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/video_dot_counter.sv
// Dot and line counters; both wrap by compare-and-clear.
module video_dot_counter
  import video_types::*;
#(
  parameter int unsigned DOTS_PER_LINE   = DefDotsPerLine,
  parameter int unsigned LINES_PER_FRAME = DefLinesPerFrame
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clear_i,
  output logic [8:0] dot_o,
  output logic [7:0] ly_o,
  output logic [7:0] ly_next_o,
  output logic       line_end_o,
  output logic       frame_end_o
);

  localparam logic [8:0] DotLast  = 9'(DOTS_PER_LINE - 1);
  localparam logic [7:0] LineLast = 8'(LINES_PER_FRAME - 1);

  logic [8:0] dot_q, dot_d;
  logic [7:0] ly_q, ly_d;
  logic       line_end, frame_end;

  assign line_end  = (dot_q == DotLast);
  assign frame_end = line_end && (ly_q == LineLast);

  always_comb begin
    dot_d = dot_q;
    ly_d  = ly_q;
    if (clear_i) begin
      dot_d = '0;
      ly_d  = '0;
    end else if (line_end) begin
      dot_d = '0;
      ly_d  = frame_end ? 8'd0 : ly_q + 8'd1;
    end else begin
      dot_d = dot_q + 9'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dot_q <= '0;
      ly_q  <= '0;
    end else begin
      dot_q <= dot_d;
      ly_q  <= ly_d;
    end
  end

  assign dot_o       = dot_q;
  assign ly_o        = ly_q;
  assign ly_next_o   = ly_d;
  assign line_end_o  = line_end;
  assign frame_end_o = frame_end;

endmodule

// File: rtl/video_line_sequencer.sv
// LCD dot/line scheduler: mode FSM, drawline strobe, VBlank/STAT interrupts.
// Build option VIDEO_SEQ_LYC_EN enables the LY==LYC compare and STAT pulse.
module video_line_sequencer
  import video_types::*;
#(
  parameter int unsigned DOTS_PER_LINE   = DefDotsPerLine,
  parameter int unsigned LINES_PER_FRAME = DefLinesPerFrame,
  parameter int unsigned VISIBLE_LINES   = DefVisibleLines,
  parameter int unsigned OAM_DOTS        = DefOamDots,
  parameter int unsigned MIN_DRAW_DOTS   = DefMinDrawDots
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lcd_en,
  input  logic        renderComplete,
  input  logic [7:0]  lyc,
  input  logic        lyc_irq_en,
  output logic        drawline,
  output logic [7:0]  ly,
  output video_mode_t mode,
  output logic        vblank_irq,
  output logic        stat_irq,
  output logic        ly_eq,
  output logic        overrun
);

  localparam logic [8:0] OamLast     = 9'(OAM_DOTS - 1);
  localparam logic [8:0] DrawMinLast = 9'(OAM_DOTS + MIN_DRAW_DOTS - 1);
  localparam logic [7:0] VisLast     = 8'(VISIBLE_LINES - 1);

  seq_state_t  state_q, state_d, next_line_st;
  video_mode_t mode_q, mode_d;
  logic        done_seen_q, done_seen_d;
  logic        drawline_q, drawline_d;
  logic        vblank_q, vblank_d;
  logic        stat_q, stat_d;
  logic        ly_eq_q, ly_eq_d;
  logic        overrun_q, overrun_d;
  logic        rc_valid, clear;

  logic [8:0]  dot;
  logic [7:0]  ly_cnt, ly_next;
  logic        line_end, frame_end;

  // Counters hold at 0 while off; the first enabled edge starts line 0, dot 0.
  assign clear = !lcd_en || (state_q == StOff);

  video_dot_counter #(
    .DOTS_PER_LINE  (DOTS_PER_LINE),
    .LINES_PER_FRAME(LINES_PER_FRAME)
  ) u_dot_counter (
    .clk_i      (clk),
    .reset_i    (reset),
    .clear_i    (clear),
    .dot_o      (dot),
    .ly_o       (ly_cnt),
    .ly_next_o  (ly_next),
    .line_end_o (line_end),
    .frame_end_o(frame_end)
  );

  always_comb begin
    state_d      = state_q;
    next_line_st = (frame_end || (ly_cnt < VisLast)) ? StOam : StVblank;
    // The renderer's report during the drawline cycle belongs to the previous line.
    rc_valid     = renderComplete && (state_q == StDraw) && !drawline_q;

    case (state_q)
      StOff: begin
        if (lcd_en) state_d = StOam;
      end
      StOam: begin
        if (dot == OamLast) state_d = StDraw;
      end
      StDraw: begin
        if (line_end) begin
          state_d = next_line_st;
        end else if ((dot >= DrawMinLast) && (done_seen_q || rc_valid)) begin
          state_d = StHblank;
        end
      end
      StHblank, StVblank: begin
        if (line_end) state_d = next_line_st;
      end
      default: state_d = StOff;
    endcase

    if (!lcd_en) state_d = StOff;

    done_seen_d = (state_q == StDraw) && (done_seen_q || rc_valid);
    drawline_d  = (state_q == StOam) && (state_d == StDraw);
    vblank_d    = lcd_en && (state_q != StOff) && line_end && (ly_cnt == VisLast);
    overrun_d   = overrun_q || (lcd_en && (state_q == StDraw) && line_end);
    mode_d      = mode_of(state_d);

`ifdef VIDEO_SEQ_LYC_EN
    ly_eq_d = (ly_next == lyc);
    stat_d  = ly_eq_d && !ly_eq_q && lyc_irq_en;
`else
    ly_eq_d = 1'b0;
    stat_d  = 1'b0;
`endif
  end

`ifndef VIDEO_SEQ_LYC_EN
  logic unused_lyc;
  assign unused_lyc = ^{lyc, lyc_irq_en, ly_next};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StOff;
      mode_q      <= MODE_HBLANK;
      done_seen_q <= 1'b0;
      drawline_q  <= 1'b0;
      vblank_q    <= 1'b0;
      stat_q      <= 1'b0;
      ly_eq_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      done_seen_q <= done_seen_d;
      drawline_q  <= drawline_d;
      vblank_q    <= vblank_d;
      stat_q      <= stat_d;
      ly_eq_q     <= ly_eq_d;
      overrun_q   <= overrun_d;
    end
  end

  assign drawline   = drawline_q;
  assign ly         = ly_cnt;
  assign mode       = mode_q;
  assign vblank_irq = vblank_q;
  assign stat_irq   = stat_q;
  assign ly_eq      = ly_eq_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_video_line_sequencer.sv
// Self-checking bench for video_line_sequencer: directed line table, full frame, random vs model.
module tb_video_line_sequencer;
  import video_types::*;

  localparam int Dots    = 456;
  localparam int Lines   = 154;
  localparam int Vis     = 144;
  localparam int OamDots = 80;
  localparam int DrawMin = 172;
  localparam int Frame   = Dots * Lines;
  localparam int NTab    = 11;
`ifdef VIDEO_SEQ_LYC_EN
  localparam bit LycOn = 1'b1;
`else
  localparam bit LycOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, lcd_en, rc, lyc_irq_en;
  logic [7:0] lyc;
  logic       drawline, vblank_irq, stat_irq, ly_eq, overrun;
  logic [7:0] ly;
  logic [1:0] mode;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  video_line_sequencer u_dut (
    .clk           (clk),
    .reset         (reset),
    .lcd_en        (lcd_en),
    .renderComplete(rc),
    .lyc           (lyc),
    .lyc_irq_en    (lyc_irq_en),
    .drawline      (drawline),
    .ly            (ly),
    .mode          (mode),
    .vblank_irq    (vblank_irq),
    .stat_irq      (stat_irq),
    .ly_eq         (ly_eq),
    .overrun       (overrun)
  );

  // Per-line stimulus: renderComplete high for dots lo..hi; hb = first HBlank dot (Dots = none).
  typedef struct {
    int lo;
    int hi;
    int hb;
    int ovr;
  } line_vec_t;
  line_vec_t tab[NTab];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pack_outs();
    return int'({drawline, ly, mode, vblank_irq, stat_irq, ly_eq, overrun});
  endfunction

  // Reference model: frame position as a single cycle index, draw end as a dot number.
  bit m_on, m_ovr, m_dl, m_vb, m_eq, m_stat;
  int m_cyc, m_end;

  function automatic int m_mode();
    int l, d;
    l = m_cyc / Dots;
    d = m_cyc % Dots;
    if (!m_on) return 0;
    if (l >= Vis) return 1;
    if (d < OamDots) return 2;
    if (d < m_end) return 3;
    return 0;
  endfunction

  function automatic int model_pack();
    return int'({m_dl, 8'(m_cyc / Dots), 2'(m_mode()), m_vb, m_stat, m_eq, m_ovr});
  endfunction

  task automatic model_step(input bit r, input bit e, input bit c, input int l_cmp,
                            input bit ie);
    int line, dot;
    bit drawing, eq_new;
    if (r) begin
      m_on = 0; m_cyc = 0; m_end = Dots; m_ovr = 0;
      m_dl = 0; m_vb = 0; m_eq = 0; m_stat = 0;
      return;
    end
    if (!e) begin
      m_on = 0; m_cyc = 0; m_end = Dots; m_dl = 0; m_vb = 0;
    end else if (!m_on) begin
      m_on = 1; m_cyc = 0; m_end = Dots; m_dl = 0; m_vb = 0;
    end else begin
      line = m_cyc / Dots;
      dot  = m_cyc % Dots;
      drawing = (line < Vis) && (dot >= OamDots) && (dot < m_end);
      if (drawing && dot == Dots - 1) m_ovr = 1;
      if (drawing && c && dot > OamDots && m_end == Dots)
        m_end = (dot + 1 > OamDots + DrawMin) ? dot + 1 : OamDots + DrawMin;
      m_vb  = (dot == Dots - 1) && (line == Vis - 1);
      m_cyc = (m_cyc + 1) % Frame;
      if (m_cyc % Dots == 0) m_end = Dots;
      m_dl = (m_cyc % Dots == OamDots) && (m_cyc / Dots < Vis);
    end
    eq_new = (m_cyc / Dots == l_cmp);
    m_stat = LycOn && eq_new && !m_eq && ie;
    m_eq   = LycOn && eq_new;
  endtask

  initial begin
    int line, dot, exp_m, first_hb, mode_bad, bad, rate, off_left;
    int n_dl, dl_bad, n_vb, vb_cyc, vb_ly, vb_mode, ly_bad, n_stat, stat_cyc, eq_cnt;

    tab[0]  = '{200, 200, 252, 0};
    tab[1]  = '{300, 300, 301, 0};
    tab[2]  = '{251, 251, 252, 0};
    tab[3]  = '{252, 252, 253, 0};
    tab[4]  = '{81, 81, 252, 0};
    tab[5]  = '{454, 454, 455, 0};
    tab[6]  = '{0, 455, 252, 0};
    tab[7]  = '{999, 0, Dots, 1};
    tab[8]  = '{80, 80, Dots, 1};
    tab[9]  = '{0, 79, Dots, 1};
    tab[10] = '{100, 100, 252, 1};

    reset = 1'b1; lcd_en = 1'b1; rc = 1'b0; lyc = 8'd5; lyc_irq_en = 1'b1;
    first_hb = Dots; mode_bad = 0;
    n_dl = 0; dl_bad = 0; n_vb = 0; vb_cyc = -1; vb_ly = -1; vb_mode = -1;
    ly_bad = 0; n_stat = 0; stat_cyc = -1; eq_cnt = 0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_outs%0d", i), pack_outs(), 0);
    end
    reset = 1'b0;
    tick();
    check("release_mode", int'(mode), 2);
    check("release_ly", int'(ly), 0);
    check("release_drawline", int'(drawline), 0);

    // One full frame from line 0, dot 0.
    for (int c = 0; c < Frame; c++) begin
      line = c / Dots;
      dot  = c % Dots;
      if (line < NTab) rc = (dot >= tab[line].lo) && (dot <= tab[line].hi);
      else if (line < Vis) rc = (dot == 260);
      else rc = 1'b1;

      if (dot == 0 && line > 0 && line <= NTab) begin
        check($sformatf("ly_line%0d", line), int'(ly), line);
        check($sformatf("overrun_after_line%0d", line - 1), int'(overrun), tab[line - 1].ovr);
        check($sformatf("oam_start_line%0d", line), int'(mode), 2);
      end
      if (int'(ly) != line) ly_bad++;
      if (drawline) begin
        n_dl++;
        if (dot != OamDots || line >= Vis || mode != 2'd3) dl_bad++;
      end
      if (vblank_irq) begin n_vb++; vb_cyc = c; vb_ly = ly; vb_mode = mode; end
      if (stat_irq) begin n_stat++; stat_cyc = c; end
      if (ly_eq) eq_cnt++;

      if (line < NTab) begin
        if (dot == 0) begin first_hb = Dots; mode_bad = 0; end
        exp_m = (dot < OamDots) ? 2 : (dot < tab[line].hb) ? 3 : 0;
        if (int'(mode) != exp_m) mode_bad++;
        if (dot >= OamDots && mode == 2'd0 && first_hb == Dots) first_hb = dot;
        if (dot == Dots - 1) begin
          check($sformatf("hblank_dot_line%0d", line), first_hb, tab[line].hb);
          check($sformatf("mode_seq_line%0d", line), mode_bad, 0);
        end
      end
      tick();
    end

    check("wrap_ly", int'(ly), 0);
    check("wrap_mode", int'(mode), 2);
    check("frame_drawlines", n_dl, Vis);
    check("drawline_misplaced", dl_bad, 0);
    check("vblank_count", n_vb, 1);
    check("vblank_cycle", vb_cyc, Vis * Dots);
    check("vblank_ly", vb_ly, Vis);
    check("vblank_mode", vb_mode, 1);
    check("ly_tracking_errors", ly_bad, 0);
    check("overrun_sticky", int'(overrun), 1);
`ifdef VIDEO_SEQ_LYC_EN
    check("stat_count", n_stat, 1);
    check("stat_cycle", stat_cyc, 5 * Dots);
    check("ly_eq_cycles", eq_cnt, Dots);
`else
    check("stat_count", n_stat, 0);
    check("ly_eq_cycles", eq_cnt, 0);
`endif

    // Reset in the middle of a draw clears everything including overrun.
    rc = 1'b0;
    for (int c = 0; c < 100; c++) tick();
    check("pre_reset_mode", int'(mode), 3);
    reset = 1'b1;
    tick();
    check("midline_reset_outs", pack_outs(), 0);
    reset = 1'b0;
    tick();
    check("post_reset_mode", int'(mode), 2);
    check("post_reset_ly", int'(ly), 0);

    // Drop lcd_en at line 3, dot 120 while a render is in flight.
    for (int c = 0; c < 3 * Dots + 120; c++) begin
      rc = (c % Dots == 260);
      tick();
    end
    rc = 1'b0;
    check("pre_drop_mode", int'(mode), 3);
    check("pre_drop_ly", int'(ly), 3);
    lcd_en = 1'b0;
    tick();
    check("drop_ly", int'(ly), 0);
    check("drop_mode", int'(mode), 0);
    check("drop_drawline", int'(drawline), 0);
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      rc = 1'($urandom_range(0, 1));
      if (drawline || mode != 2'd0 || ly != 8'd0 || vblank_irq) bad++;
      tick();
    end
    check("off_activity", bad, 0);
    check("drop_no_overrun", int'(overrun), 0);
    lcd_en = 1'b1;
    rc = 1'b0;
    tick();
    check("reenable_mode", int'(mode), 2);
    check("reenable_ly", int'(ly), 0);

    // Randomised traffic against the reference model.
    rate = 0; off_left = 0;
    for (int c = 0; c < 8000; c++) begin
      if (c % 400 == 0) rate = $urandom_range(0, 3);
      if (c % 1000 == 0) begin
        lyc        = 8'($urandom_range(0, 12));
        lyc_irq_en = 1'($urandom_range(0, 1));
      end
      reset = (c == 0) || ($urandom_range(0, 2999) == 0);
      if (off_left > 0) off_left--;
      else if ($urandom_range(0, 1499) == 0) off_left = $urandom_range(1, 20);
      lcd_en = (off_left == 0);
      case (rate)
        0:       rc = 1'b0;
        1:       rc = ($urandom_range(0, 31) == 0);
        2:       rc = ($urandom_range(0, 299) == 0);
        default: rc = 1'($urandom_range(0, 1));
      endcase
      tick();
      model_step(reset, lcd_en, rc, int'(lyc), lyc_irq_en);
      check($sformatf("rand_cycle%0d", c), pack_outs(), model_pack());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
